// File: rtl/seq_table_scheduler.sv
// Per-host sequence-number table with a three-way single-port arbiter and a
// start/done sequencer (with watchdog) for the binary-to-ASCII converter.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 4
`endif

module seq_table_scheduler #(
  parameter int          HOST_ADDR    = `HOST_ADDR_WIDTH,
  parameter int          SEQ_W        = 32,
  parameter int unsigned RESET_SEQ    = 1,
  parameter int          STARVE_LIMIT = 8,
  parameter int          CONV_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_req_i,
  input  logic [HOST_ADDR-1:0] upd_addr_i,
  input  logic [SEQ_W-1:0]     upd_seq_i,
  output logic                 upd_ack_o,
  input  logic                 lkp_req_i,
  input  logic [HOST_ADDR-1:0] lkp_addr_i,
  output logic                 lkp_ack_o,
  output logic                 lkp_valid_o,
  output logic [SEQ_W-1:0]     lkp_seq_o,
  input  logic                 out_req_i,
  input  logic [HOST_ADDR-1:0] out_addr_i,
  output logic                 out_ack_o,
  output logic                 conv_start_o,
  output logic [SEQ_W-1:0]     conv_bin_o,
  input  logic                 conv_done_i,
  output logic                 seq_ready_o,
  output logic                 conv_err_o,
  output logic                 busy_o
);

  localparam int DEPTH = 1 << HOST_ADDR;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam int WW    = $clog2(CONV_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] mem_q [DEPTH];
  logic [SEQ_W-1:0] mem_d [DEPTH];
  logic [SW-1:0]    starve_q, starve_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic [SEQ_W-1:0] lkp_seq_q, lkp_seq_d;
  logic [SEQ_W-1:0] conv_bin_q, conv_bin_d;
  logic             lkp_valid_q, lkp_valid_d;
  logic             upd_gnt_s, lkp_gnt_s, out_gnt_s;
  logic             out_elig_s, promote_s;

  // Arbiter: a starved outgoing request jumps ahead of update and lookup.
  always_comb begin
    upd_gnt_s  = 1'b0;
    lkp_gnt_s  = 1'b0;
    out_gnt_s  = 1'b0;
    out_elig_s = out_req_i && (state_q == S_IDLE);
    promote_s  = (starve_q >= SW'(STARVE_LIMIT));
    if (rst) begin
      out_gnt_s = 1'b0;
    end else if (out_elig_s && promote_s) begin
      out_gnt_s = 1'b1;
    end else if (upd_req_i) begin
      upd_gnt_s = 1'b1;
    end else if (lkp_req_i) begin
      lkp_gnt_s = 1'b1;
    end else if (out_elig_s) begin
      out_gnt_s = 1'b1;
    end else begin
      out_gnt_s = 1'b0;
    end
  end

  assign upd_ack_o = upd_gnt_s;
  assign lkp_ack_o = lkp_gnt_s;
  assign out_ack_o = out_gnt_s;

  // Datapath next-state: table write, lookup capture, converter operand.
  always_comb begin
    mem_d       = mem_q;
    starve_d    = starve_q;
    lkp_valid_d = lkp_gnt_s;
    lkp_seq_d   = lkp_gnt_s ? mem_q[lkp_addr_i] : lkp_seq_q;
    conv_bin_d  = out_gnt_s ? mem_q[out_addr_i] : conv_bin_q;
    if (upd_gnt_s) begin
      mem_d[upd_addr_i] = upd_seq_i;
    end else if (out_gnt_s) begin
      mem_d[out_addr_i] = mem_q[out_addr_i] + {{(SEQ_W-1){1'b0}}, 1'b1};
    end else begin
      mem_d = mem_q;
    end
    if (!out_req_i || out_gnt_s) begin
      starve_d = '0;
    end else if ((state_q == S_IDLE) && !promote_s) begin
      starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  // Converter sequencer next-state; done wins over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        wd_d    = '0;
        state_d = out_gnt_s ? S_START : S_IDLE;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (conv_done_i) begin
          wd_d    = '0;
          state_d = S_IDLE;
        end else if (wd_q == WW'(CONV_TIMEOUT - 1)) begin
          wd_d    = '0;
          state_d = S_IDLE;
        end else begin
          wd_d    = wd_q + {{(WW-1){1'b0}}, 1'b1};
          state_d = S_WAIT;
        end
      end
      default: begin
        wd_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Converter sequencer outputs.
  always_comb begin
    conv_start_o = 1'b0;
    seq_ready_o  = 1'b0;
    conv_err_o   = 1'b0;
    busy_o       = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
      end
      S_START: begin
        conv_start_o = 1'b1;
      end
      S_WAIT: begin
        seq_ready_o = conv_done_i;
        conv_err_o  = !conv_done_i && (wd_q == WW'(CONV_TIMEOUT - 1));
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign lkp_valid_o = lkp_valid_q;
  assign lkp_seq_o   = lkp_seq_q;
  assign conv_bin_o  = conv_bin_q;

  // State register; reset reloads the whole table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      wd_q        <= '0;
      lkp_valid_q <= 1'b0;
      lkp_seq_q   <= '0;
      conv_bin_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= SEQ_W'(RESET_SEQ);
      end
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wd_q        <= wd_d;
      lkp_valid_q <= lkp_valid_d;
      lkp_seq_q   <= lkp_seq_d;
      conv_bin_q  <= conv_bin_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_seq_table_scheduler.sv
// Scoreboard bench for seq_table_scheduler: reference model predicts grants,
// table contents and converter events; a monitor checks DUT pulses.
module tb_seq_table_scheduler;

  localparam int AW    = 4;
  localparam int SEQW  = 32;
  localparam int LIMIT = 8;
  localparam int TMO   = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            upd_req_i = 1'b0, lkp_req_i = 1'b0, out_req_i = 1'b0;
  logic [AW-1:0]   upd_addr_i = '0, lkp_addr_i = '0, out_addr_i = '0;
  logic [SEQW-1:0] upd_seq_i = '0;
  logic            conv_done_i = 1'b0;
  logic            upd_ack_o, lkp_ack_o, out_ack_o, lkp_valid_o;
  logic            conv_start_o, seq_ready_o, conv_err_o, busy_o;
  logic [SEQW-1:0] lkp_seq_o, conv_bin_o;

  seq_table_scheduler #(.HOST_ADDR(AW), .SEQ_W(SEQW), .RESET_SEQ(1),
                        .STARVE_LIMIT(LIMIT), .CONV_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .upd_req_i(upd_req_i), .upd_addr_i(upd_addr_i), .upd_seq_i(upd_seq_i),
    .upd_ack_o(upd_ack_o),
    .lkp_req_i(lkp_req_i), .lkp_addr_i(lkp_addr_i), .lkp_ack_o(lkp_ack_o),
    .lkp_valid_o(lkp_valid_o), .lkp_seq_o(lkp_seq_o),
    .out_req_i(out_req_i), .out_addr_i(out_addr_i), .out_ack_o(out_ack_o),
    .conv_start_o(conv_start_o), .conv_bin_o(conv_bin_o),
    .conv_done_i(conv_done_i), .seq_ready_o(seq_ready_o),
    .conv_err_o(conv_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int c; logic [31:0] v; } exp_t;
  typedef struct { int c; bit err; } ev_t;
  exp_t lkp_q[$];
  exp_t conv_q[$];
  ev_t  ev_q[$];

  // Reference model: spec-level arbitration, table contents and converter timing.
  initial begin : model
    logic [31:0] m_mem [16];
    bit   m_busy;
    int   m_start, m_wait;
    bit   eu, el, eo, oe;
    exp_t e;
    ev_t  ev;
    m_busy = 0; m_start = 0; m_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 16; i++) m_mem[i] = 32'd1;
        m_busy = 0; m_wait = 0; m_start = 0;
        lkp_q.delete(); conv_q.delete(); ev_q.delete();
      end else begin
        oe = out_req_i && !m_busy;
        eu = 0; el = 0; eo = 0;
        if (oe && m_wait >= LIMIT) eo = 1;
        else if (upd_req_i) eu = 1;
        else if (lkp_req_i) el = 1;
        else if (oe) eo = 1;
        chk("upd_ack", upd_ack_o, eu);
        chk("lkp_ack", lkp_ack_o, el);
        chk("out_ack", out_ack_o, eo);
        chk("busy", busy_o, (m_busy && cyc >= m_start));
        if (m_busy && cyc > m_start) begin
          if (conv_done_i) begin
            ev.c = cyc; ev.err = 0; ev_q.push_back(ev); m_busy = 0;
          end else if (cyc - m_start == TMO) begin
            ev.c = cyc; ev.err = 1; ev_q.push_back(ev); m_busy = 0;
          end
        end
        if (!out_req_i || eo) m_wait = 0;
        else if (oe) m_wait++;
        if (eu) m_mem[upd_addr_i] = upd_seq_i;
        if (el) begin
          e.c = cyc + 1; e.v = m_mem[lkp_addr_i]; lkp_q.push_back(e);
        end
        if (eo) begin
          e.c = cyc + 1; e.v = m_mem[out_addr_i]; conv_q.push_back(e);
          m_mem[out_addr_i] = m_mem[out_addr_i] + 32'd1;
          m_busy = 1; m_start = cyc + 1;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a pulse.
  initial begin : monitor
    logic [31:0] last_l, last_b;
    exp_t e;
    ev_t  ev;
    last_l = 32'd0; last_b = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        last_l = 32'd0; last_b = 32'd0;
      end else begin
        if (lkp_valid_o) begin
          chk("lkp_expected", lkp_q.size() != 0, 1);
          if (lkp_q.size() != 0) begin
            e = lkp_q.pop_front();
            chk("lkp_cycle", cyc, e.c);
            chk("lkp_seq", lkp_seq_o, e.v);
            last_l = e.v;
          end
        end else begin
          chk("lkp_hold", lkp_seq_o, last_l);
        end
        if (conv_start_o) begin
          chk("start_expected", conv_q.size() != 0, 1);
          if (conv_q.size() != 0) begin
            e = conv_q.pop_front();
            chk("start_cycle", cyc, e.c);
            chk("conv_bin", conv_bin_o, e.v);
            last_b = e.v;
          end
        end else begin
          chk("conv_bin_hold", conv_bin_o, last_b);
        end
        if (seq_ready_o || conv_err_o) begin
          chk("event_expected", ev_q.size() != 0, 1);
          chk("event_exclusive", seq_ready_o & conv_err_o, 0);
          if (ev_q.size() != 0) begin
            ev = ev_q.pop_front();
            chk("event_cycle", cyc, ev.c);
            chk("event_kind_err", conv_err_o, ev.err);
          end
        end
      end
    end
  end

  // Stimulus side
  bit a_upd, a_lkp, a_out, s_start, s_ready, s_err, s_lval;
  logic [31:0] s_bin, s_lseq;
  int resp_mode = 0;  // 0: done low, 1: random done, 2: driven by the test

  task automatic step();
    @(negedge clk);
    a_upd = upd_ack_o; a_lkp = lkp_ack_o; a_out = out_ack_o;
    s_start = conv_start_o; s_ready = seq_ready_o; s_err = conv_err_o;
    s_lval = lkp_valid_o; s_lseq = lkp_seq_o; s_bin = conv_bin_o;
    @(posedge clk);
    #1;
    if (resp_mode == 1) conv_done_i = ($urandom_range(0, 9) == 0);
    else if (resp_mode == 0) conv_done_i = 1'b0;
  endtask

  task automatic drop();
    if (a_upd) upd_req_i = 1'b0;
    if (a_lkp) lkp_req_i = 1'b0;
    if (a_out) out_req_i = 1'b0;
  endtask

  task automatic serve_all(input int bound);
    for (int i = 0; i < bound && (upd_req_i || lkp_req_i || out_req_i); i++) begin
      step(); drop();
    end
    chk("reqs_served", {upd_req_i, lkp_req_i, out_req_i}, 0);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy_o; i++) step();
    chk("idle_reached", busy_o, 0);
  endtask

  task automatic do_lkp(input logic [AW-1:0] a, input logic [31:0] exp);
    lkp_req_i = 1'b1; lkp_addr_i = a; a_lkp = 0;
    for (int i = 0; i < 10 && !a_lkp; i++) step();
    drop();
    step();
    chk("lkp_valid_direct", s_lval, 1);
    chk("lkp_value_direct", s_lseq, exp);
  endtask

  task automatic check_outs_zero(input string tag);
    chk({tag, "_ctrl"}, {upd_ack_o, lkp_ack_o, out_ack_o, lkp_valid_o, conv_start_o,
                         seq_ready_o, conv_err_o, busy_o}, 0);
    chk({tag, "_lkp_seq"}, lkp_seq_o, 0);
    chk({tag, "_conv_bin"}, conv_bin_o, 0);
  endtask

  initial begin : main
    int n;
    bit got;
    repeat (3) @(posedge clk);
    #1;
    check_outs_zero("reset");
    rst = 1'b0;

    // Outgoing host 3, done 10 cycles after start, then table holds 2
    out_req_i = 1'b1; out_addr_i = 4'd3;
    step(); chk("t1_out_ack", a_out, 1); drop();
    step(); chk("t1_start", s_start, 1); chk("t1_bin", s_bin, 32'd1);
    repeat (9) step();
    resp_mode = 2; conv_done_i = 1'b1;
    step(); chk("t1_ready", s_ready, 1);
    conv_done_i = 1'b0; resp_mode = 0;
    do_lkp(4'd3, 32'd2);

    // Update, lookup and outgoing to host 5 in the same cycle
    upd_req_i = 1'b1; upd_addr_i = 4'd5; upd_seq_i = 32'd100;
    lkp_req_i = 1'b1; lkp_addr_i = 4'd5;
    out_req_i = 1'b1; out_addr_i = 4'd5;
    step(); chk("t2_upd_first", a_upd, 1); drop();
    step(); chk("t2_lkp_second", a_lkp, 1); drop();
    step(); chk("t2_out_third", a_out, 1); chk("t2_lkp_val", s_lseq, 32'd100); drop();
    step(); chk("t2_bin", s_bin, 32'd100);
    resp_mode = 1; wait_idle(300); resp_mode = 0;
    do_lkp(4'd5, 32'd101);

    // Wrap at all-ones
    upd_req_i = 1'b1; upd_addr_i = 4'd7; upd_seq_i = 32'hFFFF_FFFF;
    serve_all(5);
    out_req_i = 1'b1; out_addr_i = 4'd7;
    serve_all(5);
    step(); chk("t3_bin", s_bin, 32'hFFFF_FFFF);
    resp_mode = 1; wait_idle(300); resp_mode = 0;
    do_lkp(4'd7, 32'd0);

    // Starvation: continuous updates must not hold off outgoing forever
    upd_req_i = 1'b1; upd_addr_i = 4'd1; upd_seq_i = 32'd50;
    out_req_i = 1'b1; out_addr_i = 4'd9;
    n = 0; a_out = 0;
    for (int i = 0; i < 20 && !a_out; i++) begin
      step();
      if (!a_out) n++;
      if (a_upd) begin upd_addr_i = 4'($urandom_range(0, 15)); upd_seq_i = $urandom; end
    end
    chk("t4_grant_within_limit", (a_out && n <= LIMIT), 1);
    out_req_i = 1'b0; upd_req_i = 1'b0;
    resp_mode = 1; wait_idle(300); resp_mode = 0;

    // Watchdog: no done, error after the timeout, next request accepted
    out_req_i = 1'b1; out_addr_i = 4'd2;
    serve_all(5);
    got = 0;
    for (int i = 0; i < TMO + 10 && !got; i++) begin step(); got = s_err; end
    chk("t5_timeout_seen", got, 1);
    out_req_i = 1'b1; out_addr_i = 4'd2;
    step(); chk("t5_next_out", a_out, 1); drop();
    resp_mode = 1; wait_idle(300); resp_mode = 0;

    // Asynchronous reset in the middle of WAIT
    out_req_i = 1'b1; out_addr_i = 4'd4;
    serve_all(5);
    repeat (5) step();
    chk("t6_in_wait", busy_o, 1);
    @(posedge clk);
    #3;
    rst = 1'b1; conv_done_i = 1'b1;
    #1;
    check_outs_zero("t6_midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; conv_done_i = 1'b0;
    for (int h = 0; h < 16; h++) do_lkp(4'(h), 32'd1);

    // Randomized traffic
    resp_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) resp_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      if (!upd_req_i && $urandom_range(0, 3) == 0) begin
        upd_req_i = 1'b1;
        upd_addr_i = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        upd_seq_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      if (!lkp_req_i && $urandom_range(0, 2) == 0) begin
        lkp_req_i = 1'b1;
        lkp_addr_i = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      end
      if (!out_req_i && $urandom_range(0, 4) == 0) begin
        out_req_i = 1'b1;
        out_addr_i = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      end
      step(); drop();
    end
    resp_mode = 1;
    serve_all(200);
    wait_idle(300);
    repeat (3) step();
    chk("lkp_q_drained", lkp_q.size(), 0);
    chk("conv_q_drained", conv_q.size(), 0);
    chk("ev_q_drained", ev_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
